// File: rtl/regfile_reader_pkg.sv
// ---------------------------------------------------------------------------
// regfile_reader_pkg
//   Shared constants and types for the RV32 register file / operand-read stage.
//   XLEN      : data width of each architectural register
//   REG_COUNT : number of architectural registers (x0 hardwired to zero)
//   AW        : register address width
//   reg_addr_t: register address type
//   REG_ZERO  : address of the hardwired-zero register
// ---------------------------------------------------------------------------
package regfile_reader_pkg;
   localparam int XLEN      = 32;
   localparam int REG_COUNT = 32;
   localparam int AW        = $clog2(REG_COUNT);

   typedef logic [AW-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_reader_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_reader_scoreboard
//   Pending-write scoreboard: one busy bit per architectural register.
//   Ports:
//     clk, rstn                : clock, async active-low reset
//     lock_enable, lock_dest   : mark a destination as awaiting write-back
//     reg_w_enable, reg_w_dest : write-back strobe, clears the busy bit
//     rs1, rs2                 : source addresses being read this cycle
//     blocked1, blocked2       : source N must wait for its write-back
// ---------------------------------------------------------------------------
module regfile_reader_scoreboard #(
   parameter int REG_COUNT = regfile_reader_pkg::REG_COUNT,
   parameter int AW        = regfile_reader_pkg::AW
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          lock_enable,
   input  logic [AW-1:0] lock_dest,
   input  logic          reg_w_enable,
   input  logic [AW-1:0] reg_w_dest,
   input  logic [AW-1:0] rs1,
   input  logic [AW-1:0] rs2,
   output logic          blocked1,
   output logic          blocked2
);
   import regfile_reader_pkg::*;

   // Bit 0 is never set (x0 writes/locks are filtered), so it stays 0 and
   // keeps the array indexable by any address.
   logic [REG_COUNT-1:0] busy;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy <= '0;
      end else begin
         if (reg_w_enable && reg_w_dest != REG_ZERO)
            busy[reg_w_dest] <= 1'b0;
         // Placed after the clear: a new pending writer wins over a
         // same-cycle write-back to the same register.
         if (lock_enable && lock_dest != REG_ZERO)
            busy[lock_dest] <= 1'b1;
      end
   end

   // A write-back landing this cycle resolves the hazard (it is forwarded).
   // Uses the pre-update busy state, so a same-cycle lock never blocks.
   always_comb begin
      blocked1 = (rs1 != REG_ZERO) && busy[rs1] &&
                 !(reg_w_enable && reg_w_dest == rs1);
      blocked2 = (rs2 != REG_ZERO) && busy[rs2] &&
                 !(reg_w_enable && reg_w_dest == rs2);
   end
endmodule

// File: rtl/regfile_reader.sv
// ---------------------------------------------------------------------------
// regfile_reader
//   Register file plus registered two-operand read stage with write-back
//   forwarding and pending-write stall.
//   Ports:
//     clk, rstn                            : clock, async active-low reset
//     enabled / completed                  : read request / read done
//     rs1, rs2 -> rs1_data, rs2_data       : source addresses / operands
//     lock_enable, lock_dest               : mark destination pending
//     reg_w_enable, reg_w_dest, reg_w_data : write-back bus
//     stalled                              : enabled && hazard (comb.)
// ---------------------------------------------------------------------------
module regfile_reader #(
   parameter int XLEN      = regfile_reader_pkg::XLEN,
   parameter int REG_COUNT = regfile_reader_pkg::REG_COUNT,
   parameter int AW        = regfile_reader_pkg::AW
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            enabled,
   output logic            completed,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic            lock_enable,
   input  logic [AW-1:0]   lock_dest,
   input  logic            reg_w_enable,
   input  logic [AW-1:0]   reg_w_dest,
   input  logic [XLEN-1:0] reg_w_data,
   output logic            stalled
);
   import regfile_reader_pkg::*;

   logic [XLEN-1:0] regs [REG_COUNT];
   logic            blocked1, blocked2, hazard;
   logic [XLEN-1:0] op1, op2;

   regfile_reader_scoreboard #(.REG_COUNT(REG_COUNT), .AW(AW)) u_sb (
      .clk          (clk),
      .rstn         (rstn),
      .lock_enable  (lock_enable),
      .lock_dest    (lock_dest),
      .reg_w_enable (reg_w_enable),
      .reg_w_dest   (reg_w_dest),
      .rs1          (rs1),
      .rs2          (rs2),
      .blocked1     (blocked1),
      .blocked2     (blocked2)
   );

   assign hazard  = blocked1 || blocked2;
   assign stalled = enabled && hazard;

   // Operand select: x0, then same-cycle write-back forward, then array.
   always_comb begin
      op1 = regs[rs1];
      op2 = regs[rs2];
      if (reg_w_enable && reg_w_dest == rs1) op1 = reg_w_data;
      if (reg_w_enable && reg_w_dest == rs2) op2 = reg_w_data;
      if (rs1 == REG_ZERO) op1 = '0;
      if (rs2 == REG_ZERO) op2 = '0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (reg_w_enable && reg_w_dest != REG_ZERO) begin
         regs[reg_w_dest] <= reg_w_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         completed <= 1'b0;
         rs1_data  <= '0;
         rs2_data  <= '0;
      end else if (enabled && !hazard) begin
         completed <= 1'b1;
         rs1_data  <= op1;
         rs2_data  <= op2;
      end else begin
         completed <= 1'b0;
      end
   end
endmodule

// File: tb/tb_regfile_reader.sv
// ---------------------------------------------------------------------------
// tb_regfile_reader
//   Directed self-checking bench for regfile_reader. Inputs are driven just
//   after the falling edge; registered outputs are sampled 1 time unit after
//   the rising edge, the combinational stall just before it.
// ---------------------------------------------------------------------------
module tb_regfile_reader;
   logic        clk = 1'b0;
   logic        rstn;
   logic        enabled;
   logic        completed;
   logic [4:0]  rs1, rs2;
   logic [31:0] rs1_data, rs2_data;
   logic        lock_enable;
   logic [4:0]  lock_dest;
   logic        reg_w_enable;
   logic [4:0]  reg_w_dest;
   logic [31:0] reg_w_data;
   logic        stalled;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   regfile_reader dut (
      .clk          (clk),
      .rstn         (rstn),
      .enabled      (enabled),
      .completed    (completed),
      .rs1          (rs1),
      .rs2          (rs2),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .lock_enable  (lock_enable),
      .lock_dest    (lock_dest),
      .reg_w_enable (reg_w_enable),
      .reg_w_dest   (reg_w_dest),
      .reg_w_data   (reg_w_data),
      .stalled      (stalled)
   );

   task automatic drive_idle();
      @(negedge clk);
      enabled = 0; rs1 = 0; rs2 = 0;
      lock_enable = 0; lock_dest = 0;
      reg_w_enable = 0; reg_w_dest = 0; reg_w_data = 0;
   endtask

   task automatic post_edge();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rstn = 0;
      enabled = 0; rs1 = 0; rs2 = 0;
      lock_enable = 0; lock_dest = 0;
      reg_w_enable = 0; reg_w_dest = 0; reg_w_data = 0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (completed !== 1'b0) begin n_bad++; $display("FAIL reset_completed got %b want 0", completed); end
      n_cmp++; if (rs1_data !== 32'h0) begin n_bad++; $display("FAIL reset_rs1 got %h want 0", rs1_data); end
      n_cmp++; if (rs2_data !== 32'h0) begin n_bad++; $display("FAIL reset_rs2 got %h want 0", rs2_data); end
      @(negedge clk); rstn = 1;
   endtask

   task automatic test_x0_read();
      drive_idle();
      enabled = 1; rs1 = 0; rs2 = 5; #1;
      n_cmp++; if (stalled !== 1'b0) begin n_bad++; $display("FAIL x0_stalled got %b want 0", stalled); end
      post_edge();
      n_cmp++; if (completed !== 1'b1) begin n_bad++; $display("FAIL x0_completed got %b want 1", completed); end
      n_cmp++; if (rs1_data !== 32'h0) begin n_bad++; $display("FAIL x0_rs1 got %h want 0", rs1_data); end
      n_cmp++; if (rs2_data !== 32'h0) begin n_bad++; $display("FAIL x0_rs2 got %h want 0", rs2_data); end
      drive_idle(); post_edge();
      n_cmp++; if (completed !== 1'b0) begin n_bad++; $display("FAIL x0_idle_completed got %b want 0", completed); end
   endtask

   task automatic test_write_read();
      drive_idle();
      reg_w_enable = 1; reg_w_dest = 7; reg_w_data = 32'hDEADBEEF;
      drive_idle();
      enabled = 1; rs1 = 7; rs2 = 7;
      post_edge();
      n_cmp++; if (completed !== 1'b1) begin n_bad++; $display("FAIL wr_completed got %b want 1", completed); end
      n_cmp++; if (rs1_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_rs1 got %h want deadbeef", rs1_data); end
      n_cmp++; if (rs2_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_rs2 got %h want deadbeef", rs2_data); end
      // x0 write is discarded
      drive_idle();
      reg_w_enable = 1; reg_w_dest = 0; reg_w_data = 32'h1234;
      drive_idle();
      enabled = 1; rs1 = 0; rs2 = 7;
      post_edge();
      n_cmp++; if (rs1_data !== 32'h0) begin n_bad++; $display("FAIL x0_write_rs1 got %h want 0", rs1_data); end
      n_cmp++; if (rs2_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL x0_write_rs2 got %h want deadbeef", rs2_data); end
   endtask

   task automatic test_stall_forward();
      drive_idle();
      lock_enable = 1; lock_dest = 3;
      drive_idle();
      enabled = 1; rs1 = 3; rs2 = 0;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_cmp++; if (stalled !== 1'b1) begin n_bad++; $display("FAIL stall_stalled[%0d] got %b want 1", c, stalled); end
         post_edge();
         n_cmp++; if (completed !== 1'b0) begin n_bad++; $display("FAIL stall_completed[%0d] got %b want 0", c, completed); end
         n_cmp++; if (rs1_data !== 32'h0) begin n_bad++; $display("FAIL stall_hold_rs1[%0d] got %h want 0", c, rs1_data); end
         @(negedge clk);
      end
      reg_w_enable = 1; reg_w_dest = 3; reg_w_data = 32'h55; #1;
      n_cmp++; if (stalled !== 1'b0) begin n_bad++; $display("FAIL fwd_stalled got %b want 0", stalled); end
      post_edge();
      n_cmp++; if (completed !== 1'b1) begin n_bad++; $display("FAIL fwd_completed got %b want 1", completed); end
      n_cmp++; if (rs1_data !== 32'h55) begin n_bad++; $display("FAIL fwd_rs1 got %h want 55", rs1_data); end
      // busy[3] must be clear now
      drive_idle();
      enabled = 1; rs1 = 3; rs2 = 0; #1;
      n_cmp++; if (stalled !== 1'b0) begin n_bad++; $display("FAIL cleared_stalled got %b want 0", stalled); end
      post_edge();
      n_cmp++; if (rs1_data !== 32'h55) begin n_bad++; $display("FAIL cleared_rs1 got %h want 55", rs1_data); end
   endtask

   task automatic test_lock_write_same();
      drive_idle();
      lock_enable = 1; lock_dest = 9;
      reg_w_enable = 1; reg_w_dest = 9; reg_w_data = 32'hA;
      drive_idle();
      enabled = 1; rs1 = 0; rs2 = 9;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_cmp++; if (stalled !== 1'b1) begin n_bad++; $display("FAIL lw_stalled[%0d] got %b want 1", c, stalled); end
         post_edge();
         n_cmp++; if (completed !== 1'b0) begin n_bad++; $display("FAIL lw_completed[%0d] got %b want 0", c, completed); end
         @(negedge clk);
      end
      reg_w_enable = 1; reg_w_dest = 9; reg_w_data = 32'hB;
      post_edge();
      n_cmp++; if (completed !== 1'b1) begin n_bad++; $display("FAIL lw_release_completed got %b want 1", completed); end
      n_cmp++; if (rs2_data !== 32'hB) begin n_bad++; $display("FAIL lw_release_rs2 got %h want b", rs2_data); end
   endtask

   task automatic test_lock_read_same();
      // Read of reg 7 in the same cycle it is locked is not blocked.
      drive_idle();
      enabled = 1; rs1 = 7; rs2 = 0; lock_enable = 1; lock_dest = 7; #1;
      n_cmp++; if (stalled !== 1'b0) begin n_bad++; $display("FAIL lr_stalled got %b want 0", stalled); end
      post_edge();
      n_cmp++; if (rs1_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lr_rs1 got %h want deadbeef", rs1_data); end
      @(negedge clk);
      lock_enable = 0; #1;
      n_cmp++; if (stalled !== 1'b1) begin n_bad++; $display("FAIL lr_next_stalled got %b want 1", stalled); end
      drive_idle();
      reg_w_enable = 1; reg_w_dest = 7; reg_w_data = 32'hDEADBEEF;
      drive_idle();
   endtask

   task automatic test_reset_mid_stall();
      drive_idle();
      enabled = 1; rs1 = 7; rs2 = 0; lock_enable = 1; lock_dest = 4;
      post_edge();
      n_cmp++; if (completed !== 1'b1) begin n_bad++; $display("FAIL rst_pre_completed got %b want 1", completed); end
      @(negedge clk);
      lock_enable = 0; rs1 = 4; #1;
      n_cmp++; if (stalled !== 1'b1) begin n_bad++; $display("FAIL rst_pre_stalled got %b want 1", stalled); end
      #1 rstn = 0; #1;
      n_cmp++; if (completed !== 1'b0) begin n_bad++; $display("FAIL rst_async_completed got %b want 0", completed); end
      n_cmp++; if (rs1_data !== 32'h0) begin n_bad++; $display("FAIL rst_async_rs1 got %h want 0", rs1_data); end
      n_cmp++; if (stalled !== 1'b0) begin n_bad++; $display("FAIL rst_async_stalled got %b want 0", stalled); end
      @(negedge clk);
      rstn = 1; enabled = 1; rs1 = 4; rs2 = 7; #1;
      n_cmp++; if (stalled !== 1'b0) begin n_bad++; $display("FAIL rst_after_stalled got %b want 0", stalled); end
      post_edge();
      n_cmp++; if (completed !== 1'b1) begin n_bad++; $display("FAIL rst_after_completed got %b want 1", completed); end
      n_cmp++; if (rs1_data !== 32'h0) begin n_bad++; $display("FAIL rst_after_rs1 got %h want 0", rs1_data); end
      n_cmp++; if (rs2_data !== 32'h0) begin n_bad++; $display("FAIL rst_after_rs2 got %h want 0", rs2_data); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [3];
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
      for (int i = 0; i < 3; i++) begin
         drive_idle();
         reg_w_enable = 1; reg_w_dest = 5'(i + 1); reg_w_data = vals[i];
      end
      for (int i = 0; i < 3; i++) begin
         drive_idle();
         enabled = 1; rs1 = 5'(i + 1); rs2 = 0;
         post_edge();
         n_cmp++; if (completed !== 1'b1) begin n_bad++; $display("FAIL b2b_completed[%0d] got %b want 1", i, completed); end
         n_cmp++; if (rs1_data !== vals[i]) begin n_bad++; $display("FAIL b2b_rs1[%0d] got %h want %h", i, rs1_data, vals[i]); end
      end
      drive_idle(); post_edge();
      n_cmp++; if (completed !== 1'b0) begin n_bad++; $display("FAIL b2b_end_completed got %b want 0", completed); end
      n_cmp++; if (rs1_data !== 32'h33) begin n_bad++; $display("FAIL b2b_hold_rs1 got %h want 33", rs1_data); end
   endtask

   initial begin
      test_reset();
      test_x0_read();
      test_write_read();
      test_stall_forward();
      test_lock_write_same();
      test_lock_read_same();
      test_reset_mid_stall();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/regfile_reader.md
Name: regfile_reader

Overview:
- Register file plus operand-read stage of the multi-cycle RV32 core.
- Accepts the write-back bus (reg_w_enable/reg_w_dest/reg_w_data) from the write stage.
- Serves registered two-operand reads to decode/execute under the enabled/completed control handshake.
- A per-register pending-write scoreboard stalls reads of registers whose write-back has not yet happened.

Parameters:
XLEN, 32, data width of each register
REG_COUNT, 32, number of architectural registers; x0 hardwired to zero
AW, 5, register address width (log2 REG_COUNT)

Ports:
clk  input  1  clock; all state updates on rising edge
rstn  input  1  asynchronous active-low reset
enabled  input  1  read request; held high by controller until completed seen
completed  output  1  read done; operand outputs valid this cycle
rs1  input  AW  source register 1 address
rs2  input  AW  source register 2 address
rs1_data  output  XLEN  registered operand 1
rs2_data  output  XLEN  registered operand 2
lock_enable  input  1  marks lock_dest as pending write (issued instruction writes rd)
lock_dest  input  AW  destination being locked
reg_w_enable  input  1  write-back strobe from write stage
reg_w_dest  input  AW  write-back destination
reg_w_data  input  XLEN  write-back data
stalled  output  1  combinational: enabled && hazard this cycle

Behaviour:
- Reset (rstn low, asynchronous, any time incl. mid-read):
  - all registers = 0; all busy bits = 0
  - completed = 0; rs1_data = rs2_data = 0
  - an in-flight read is dropped; controller must re-request.
- Write port:
  - on posedge with reg_w_enable && reg_w_dest != 0: regs[reg_w_dest] <= reg_w_data and busy[reg_w_dest] <= 0.
  - writes to x0 are ignored; x0 always reads 0.
- Lock port:
  - on posedge with lock_enable && lock_dest != 0: busy[lock_dest] <= 1.
  - lock_dest = 0 is ignored.
  - Lock and write to the same register in the same cycle: data is written, busy ends 1 (the new pending writer wins).
- Hazard, per source rsN:
  - blockedN = rsN != 0 && busy[rsN] && !(reg_w_enable && reg_w_dest == rsN).
  - hazard = blocked1 || blocked2.
- Read, evaluated at each posedge:
  - enabled && !hazard: completed <= 1, and each operand is captured:
    - rsN == 0 → 0
    - else if reg_w_enable && reg_w_dest == rsN → reg_w_data (same-cycle forward)
    - else → regs[rsN].
  - otherwise: completed <= 0; rs1_data/rs2_data hold their previous values.
- Latency and handshake:
  - 1 cycle from enabled (no hazard) to completed.
  - completed stays 1 on consecutive cycles while enabled remains high and no hazard; operands re-captured each cycle.
  - Stall length = cycles until the matching write-back; completed rises on the cycle after the forwarding write.
- Lock and read in the same cycle on the same register: the read uses pre-lock busy state, so the lock does not block that read.
- Addresses ≥ REG_COUNT cannot occur (AW sized exactly).
- Implement rs1_data/rs2_data and completed as flops.

Decomposition:
- Shared package (def.sv):
  - reg_addr_t (AW-bit) typedef
  - REG_ZERO constant = 0
  - XLEN, REG_COUNT constants
- Natural sub-module: regfile_scoreboard. Holds busy[REG_COUNT-1:1], takes lock and write-back strobes, and returns per-source blocked flags for rs1/rs2.
- Data array and read/forward logic stay in regfile_reader.

Test Plan:
- Reset, then enabled=1, rs1=0, rs2=5 → next cycle completed=1, rs1_data=0, rs2_data=0; stalled=0.
- Write reg 7 = 0xDEADBEEF; next cycle enabled, rs1=7, rs2=7 → completed=1, both operands 0xDEADBEEF. Separately, write x0 = 0x1234, then read rs1=0 → 0.
- Lock reg 3, then enabled with rs1=3 for 4 cycles → stalled=1 and completed=0 throughout. In cycle 5 drive reg_w_enable, dest=3, data=0x55 → completed=1 next cycle, rs1_data=0x55 (forwarded), busy[3] cleared.
- Same cycle: lock_enable dest=9 and reg_w_enable dest=9 data=0xA → regs[9]=0xA, busy[9]=1; a subsequent read of rs2=9 stalls until the next write to 9.
- Locked reg 4 with enabled high → assert rstn=0 asynchronously mid-stall → completed, operands and busy bits immediately 0. After release, a read of rs1=4 completes in 1 cycle with 0.
- Back-to-back: enabled held 3 cycles, rs1=1 then 2 then 3 with preloaded values 0x11/0x22/0x33 → completed=1 on cycles 2-4, rs1_data tracks 0x11, 0x22, 0x33.
